// File: rtl/uart_alu_sequencer.sv
// rtl/uart_alu_sequencer.sv - UART byte sequencer: A, B, opcode -> ALU -> result byte
// Optional inter-byte timeout is built when ALU_SEQ_TIMEOUT_EN is defined.
module uart_alu_sequencer #(
    parameter int          NB_DATA        = 8,
    parameter int          NB_OP          = 6,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_a,
    output logic [NB_DATA-1:0] o_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [2:0]         o_state,
    output logic               o_overrun,
    output logic               o_err_op,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    localparam logic [NB_OP-1:0]   OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0]   OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0]   OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0]   OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0]   OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0]   OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0]   OP_SRL = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0]   OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

    state_t             r_state;
    state_t             w_next;
    logic [NB_DATA-1:0] r_a;
    logic [NB_DATA-1:0] r_b;
    logic [NB_OP-1:0]   r_op;
    logic [NB_DATA-1:0] r_tx_data;
    logic               r_tx_start;
    logic               r_overrun;
    logic               r_err_op;
    logic [NB_DATA-1:0] w_result;
    logic               w_err;
    logic               w_expire;
    logic               w_busy;

    // Bytes arriving while a result is being produced or sent have nowhere to go.
    assign w_busy = (r_state == EXEC) || (r_state == SEND) || (r_state == WAIT_TX);

`ifdef ALU_SEQ_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        r_timeout;
    logic        w_in_wait;

    assign w_in_wait = (r_state == WAIT_B) || (r_state == WAIT_OP);
    // A byte landing in the expiry cycle wins, so i_rx_done masks the abort.
    assign w_expire  = w_in_wait && !i_rx_done && (r_to_cnt == TIMEOUT_CYCLES - 16'd1);

    // Inter-byte counter: runs only while waiting for B or the opcode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_to_cnt  <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (i_rx_done || !w_in_wait || w_expire) begin
                r_to_cnt <= 16'd0;
            end else begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_expire  = 1'b0;
    // Constant zero; the term only keeps the parameter referenced in this build.
    assign o_timeout = 1'b0 & (TIMEOUT_CYCLES != 16'd0);
`endif

    // ALU on the latched operands; unsupported opcodes yield zero and flag an error.
    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (r_op)
            OP_ADD:  w_result = r_a + r_b;
            OP_SUB:  w_result = r_a - r_b;
            OP_AND:  w_result = r_a & r_b;
            OP_OR:   w_result = r_a | r_b;
            OP_XOR:  w_result = r_a ^ r_b;
            OP_NOR:  w_result = ~(r_a | r_b);
            OP_SRL:  w_result = (r_b >= SHIFT_LIMIT) ? '0 : (r_a >> r_b);
            OP_SRA:  w_result = (r_b >= SHIFT_LIMIT) ? {NB_DATA{r_a[NB_DATA-1]}}
                                                     : NB_DATA'($signed(r_a) >>> r_b);
            default: w_err    = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= WAIT_A;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; unused encodings fall back to WAIT_A.
    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_A:  if (i_rx_done) w_next = WAIT_B;
            WAIT_B:  if (i_rx_done) w_next = WAIT_OP;
                     else if (w_expire) w_next = WAIT_A;
            WAIT_OP: if (i_rx_done) w_next = EXEC;
                     else if (w_expire) w_next = WAIT_A;
            EXEC:    w_next = SEND;
            SEND:    w_next = WAIT_TX;
            WAIT_TX: if (i_tx_done) w_next = WAIT_A;
            default: w_next = WAIT_A;
        endcase
    end

    // Operand capture, result register, one-cycle start strobe and sticky overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_overrun  <= 1'b0;
            r_err_op   <= 1'b0;
        end else begin
            r_tx_start <= (r_state == EXEC);
            if (i_rx_done && (r_state == WAIT_A)) r_a <= i_rx_data;
            if (i_rx_done && (r_state == WAIT_B)) r_b <= i_rx_data;
            if (i_rx_done && (r_state == WAIT_OP)) r_op <= i_rx_data[NB_OP-1:0];
            if (r_state == EXEC) begin
                r_tx_data <= w_result;
                r_err_op  <= w_err;
            end
            if (i_rx_done && w_busy) r_overrun <= 1'b1;
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_a        = r_a;
    assign o_b        = r_b;
    assign o_op       = r_op;
    assign o_state    = r_state;
    assign o_overrun  = r_overrun;
    assign o_err_op   = r_err_op;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb/tb_uart_alu_sequencer.sv - randomized self-checking bench for uart_alu_sequencer
module tb_uart_alu_sequencer;

    localparam int TMO = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done = 1'b0;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic [7:0] o_a;
    logic [7:0] o_b;
    logic [5:0] o_op;
    logic [2:0] o_state;
    logic       o_overrun;
    logic       o_err_op;
    logic       o_timeout;

    int n_checks = 0;
    int n_errors = 0;
    bit exp_overrun = 1'b0;

    uart_alu_sequencer #(
        .NB_DATA        (8),
        .NB_OP          (6),
        .TIMEOUT_CYCLES (16'(TMO))
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .i_rx_data  (i_rx_data),
        .i_rx_done  (i_rx_done),
        .i_tx_done  (i_tx_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_a        (o_a),
        .o_b        (o_b),
        .o_op       (o_op),
        .o_state    (o_state),
        .o_overrun  (o_overrun),
        .o_err_op   (o_err_op),
        .o_timeout  (o_timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
    endtask

    // Reference ALU written as plain integer arithmetic on the opcode table.
    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op, output bit err);
        int ia, ib, r, sa, d;
        ia  = int'(a);
        ib  = int'(b);
        err = 1'b0;
        r   = 0;
        case (op)
            6'h20: r = ia + ib;
            6'h22: r = ia - ib;
            6'h24: r = ia & ib;
            6'h25: r = ia | ib;
            6'h26: r = ia ^ ib;
            6'h27: r = 255 - (ia | ib);
            6'h02: r = (ib >= 8) ? 0 : ia / (1 << ib);
            6'h03: begin
                sa = (ia >= 128) ? ia - 256 : ia;
                d  = 1 << ((ib >= 8) ? 8 : ib);
                r  = (sa >= 0) ? sa / d : -((-sa + d - 1) / d);
            end
            default: begin
                r   = 0;
                err = 1'b1;
            end
        endcase
        r = r & 255;
        return r[7:0];
    endfunction

    // Called right after the opcode byte was sampled.
    task automatic finish_txn(input logic [7:0] exp_data, input bit exp_err, input bit inject);
        check("exec_state", 32'(o_state), 32'd3);
        check("start_early", 32'(o_tx_start), 32'd0);
        tick();
        check("start_pulse", 32'(o_tx_start), 32'd1);
        check("send_state", 32'(o_state), 32'd4);
        check("tx_data", 32'(o_tx_data), 32'(exp_data));
        check("err_op", 32'(o_err_op), 32'(exp_err));
        check("timeout_idle", 32'(o_timeout), 32'd0);
        tick();
        check("start_once", 32'(o_tx_start), 32'd0);
        check("wait_tx_state", 32'(o_state), 32'd5);
        gap();
        if (inject) begin
            send_byte(8'h55);
            exp_overrun = 1'b1;
            check("overrun_state", 32'(o_state), 32'd5);
        end
        check("tx_hold", 32'(o_tx_data), 32'(exp_data));
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("done_state", 32'(o_state), 32'd0);
        check("overrun", 32'(o_overrun), 32'(exp_overrun));
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input bit inject);
        logic [7:0] exp;
        bit         err;
        gap();
        send_byte(a);
        check("latch_a", 32'(o_a), 32'(a));
        gap();
        send_byte(b);
        check("latch_b", 32'(o_b), 32'(b));
        gap();
        send_byte(opb);
        check("latch_op", 32'(o_op), 32'(opb[5:0]));
        exp = ref_alu(a, b, opb[5:0], err);
        finish_txn(exp, err, inject);
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [7:0] ra, rb, rop;
        int         sel, found;
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

        // Reset values while reset is held.
        #12;
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_outputs", {o_tx_data, o_a, o_b, 2'b00, o_op}, 32'd0);
        check("rst_flags", {28'd0, o_tx_start, o_overrun, o_err_op, o_timeout}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();

        // Directed vectors.
        run_txn(8'h03, 8'h02, 8'h20, 1'b0);
        run_txn(8'h02, 8'h03, 8'h22, 1'b0);
        run_txn(8'h80, 8'h01, 8'h03, 1'b0);
        run_txn(8'h80, 8'h09, 8'h02, 1'b0);
        run_txn(8'h80, 8'h09, 8'h03, 1'b0);
        run_txn(8'h81, 8'h08, 8'h02, 1'b0);
        run_txn(8'h12, 8'h34, 8'h3F, 1'b0);
        run_txn(8'h01, 8'h01, 8'h20, 1'b0);

        // i_tx_done outside WAIT_TX is ignored.
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("txdone_in_wait_a", 32'(o_state), 32'd0);
        send_byte(8'h07);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("txdone_in_wait_b", 32'(o_state), 32'd1);
        send_byte(8'h01);
        send_byte(8'h26);
        finish_txn(8'h06, 1'b0, 1'b1);

        // After an overrun the next byte is operand A.
        run_txn(8'h11, 8'h22, 8'h20, 1'b0);

`ifdef ALU_SEQ_TIMEOUT_EN
        send_byte(8'h03);
        found = 0;
        for (int i = 1; i <= 4 * TMO; i++) begin
            tick();
            if (o_timeout === 1'b1) begin
                found = i;
                break;
            end
        end
        check("tmo_latency", 32'(found), 32'(TMO));
        check("tmo_state", 32'(o_state), 32'd0);
        tick();
        check("tmo_one_cycle", 32'(o_timeout), 32'd0);
        send_byte(8'h03);
        repeat (TMO - 1) tick();
        check("tmo_pre_expiry", 32'(o_state), 32'd1);
        send_byte(8'h04);
        check("tmo_priority_state", 32'(o_state), 32'd2);
        check("tmo_priority_pulse", 32'(o_timeout), 32'd0);
        tick();
        check("tmo_priority_quiet", 32'(o_timeout), 32'd0);
        send_byte(8'h20);
        finish_txn(8'h07, 1'b0, 1'b0);
`else
        send_byte(8'h03);
        found = 0;
        for (int i = 0; i < 6 * TMO; i++) begin
            tick();
            if (o_timeout !== 1'b0 || o_state !== 3'd1) found++;
        end
        check("no_tmo_wait", 32'(found), 32'd0);
        send_byte(8'h04);
        send_byte(8'h20);
        finish_txn(8'h07, 1'b0, 1'b0);
`endif

        // Randomized transactions against the reference model.
        for (int t = 0; t < 24; t++) begin
            sel = $urandom_range(0, 9);
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 8'($urandom_range(0, 255));
            if (sel < 8) rop[5:0] = ops[sel];
            if (rop[5:0] == 6'h02 || rop[5:0] == 6'h03) rb = 8'($urandom_range(0, 10));
            run_txn(ra, rb, rop, ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset in WAIT_OP.
        send_byte(8'h5A);
        send_byte(8'hA5);
        check("pre_reset_state", 32'(o_state), 32'd2);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_state", 32'(o_state), 32'd0);
        check("async_rst_outputs", {o_tx_data, o_a, o_b, 2'b00, o_op}, 32'd0);
        check("async_rst_flags", {28'd0, o_tx_start, o_overrun, o_err_op, o_timeout}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_overrun = 1'b0;
        run_txn(8'h01, 8'h01, 8'h20, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
